// File: rtl/instr_fetch_decode.sv
// Multi-cycle fetch/decode/writeback controller feeding a 16-bit ALU.
// Owns the PC, an 8x16 register file, the hi/lo pair and the run/halt state.
module instr_fetch_decode #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [15:0]         imem_data,
    output logic [3:0]          op_code,
    output logic [15:0]         rs_val,
    output logic [15:0]         rt_val,
    output logic [2:0]          shamt,
    output logic [5:0]          constant,
    input  logic [15:0]         alu_rd,
    input  logic [15:0]         alu_hi,
    input  logic [15:0]         alu_lo,
    output logic [PC_WIDTH-1:0] pc,
    output logic                busy,
    output logic                halted,
    input  logic [2:0]          dbg_addr,
    output logic [15:0]         dbg_data
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic [15:0]         hi_q, hi_d;
    logic [15:0]         lo_q, lo_d;
    logic [15:0]         regs_q [8];
    logic [15:0]         regs_d [8];
    logic [3:0]          op_code_q, op_code_d;
    logic [15:0]         rs_val_q, rs_val_d;
    logic [15:0]         rt_val_q, rt_val_d;
    logic [2:0]          shamt_q, shamt_d;
    logic [5:0]          constant_q, constant_d;
    logic [15:0]         res_rd_q, res_rd_d;
    logic [15:0]         res_hi_q, res_hi_d;
    logic [15:0]         res_lo_q, res_lo_d;
    logic                imem_req_q, imem_req_d;
    logic                busy_q, busy_d;
    logic                halted_q, halted_d;

    logic [2:0]          rd_idx, rs_idx, rt_idx;
    logic                wr_en;
    logic [15:0]         wr_data;

    assign rd_idx = ir_q[11:9];
    assign rs_idx = ir_q[8:6];
    assign rt_idx = ir_q[5:3];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        regs_d     = regs_q;
        op_code_d  = op_code_q;
        rs_val_d   = rs_val_q;
        rt_val_d   = rt_val_q;
        shamt_d    = shamt_q;
        constant_d = constant_q;
        res_rd_d   = res_rd_q;
        res_hi_d   = res_hi_q;
        res_lo_d   = res_lo_q;
        wr_en      = 1'b0;
        wr_data    = res_rd_q;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                op_code_d  = ir_q[15:12];
                shamt_d    = ir_q[2:0];
                constant_d = ir_q[5:0];
                rs_val_d   = (rs_idx == 3'd0) ? 16'h0000 : regs_q[rs_idx];
                rt_val_d   = (rt_idx == 3'd0) ? 16'h0000 : regs_q[rt_idx];
                state_d    = (ir_q[15:12] == 4'd15) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                res_rd_d = alu_rd;
                res_hi_d = alu_hi;
                res_lo_d = alu_lo;
                state_d  = S_WB;
            end
            S_WB: begin
                case (op_code_q)
                    4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10: begin
                        wr_en   = 1'b1;
                        wr_data = res_rd_q;
                    end
                    4'd3: begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                    // mflo/mfhi read the architectural pair, not the ALU outputs
                    4'd4: begin
                        wr_en   = 1'b1;
                        wr_data = lo_q;
                    end
                    4'd5: begin
                        wr_en   = 1'b1;
                        wr_data = hi_q;
                    end
                    default: wr_en = 1'b0;
                endcase
                if (wr_en && rd_idx != 3'd0) regs_d[rd_idx] = wr_data;
                pc_d    = pc_q + PC_WIDTH'(1);
                state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        imem_req_d = (state_d == S_FETCH);
        busy_d     = (state_d == S_FETCH) || (state_d == S_DECODE) ||
                     (state_d == S_EXEC)  || (state_d == S_WB);
        halted_d   = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
            op_code_q  <= '0;
            rs_val_q   <= '0;
            rt_val_q   <= '0;
            shamt_q    <= '0;
            constant_q <= '0;
            res_rd_q   <= '0;
            res_hi_q   <= '0;
            res_lo_q   <= '0;
            imem_req_q <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
            op_code_q  <= op_code_d;
            rs_val_q   <= rs_val_d;
            rt_val_q   <= rt_val_d;
            shamt_q    <= shamt_d;
            constant_q <= constant_d;
            res_rd_q   <= res_rd_d;
            res_hi_q   <= res_hi_d;
            res_lo_q   <= res_lo_d;
            imem_req_q <= imem_req_d;
            busy_q     <= busy_d;
            halted_q   <= halted_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign op_code   = op_code_q;
    assign rs_val    = rs_val_q;
    assign rt_val    = rt_val_q;
    assign shamt     = shamt_q;
    assign constant  = constant_q;
    assign busy      = busy_q;
    assign halted    = halted_q;
    assign dbg_data  = (dbg_addr == 3'd0) ? 16'h0000 : regs_q[dbg_addr];

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: small ALU model, imem driver tasks,
// and a second PC_WIDTH=2 instance for the PC wrap case.
module tb_instr_fetch_decode;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [3:0]  op_code;
    logic [15:0] rs_val, rt_val;
    logic [2:0]  shamt;
    logic [5:0]  constant;
    logic [15:0] alu_rd, alu_hi, alu_lo;
    logic [7:0]  pc;
    logic        busy, halted;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    logic        start2, imem_req2, busy2, halted2;
    logic [1:0]  imem_addr2, pc2;
    logic [3:0]  op_code2;
    logic [15:0] rs_val2, rt_val2, dbg_data2;
    logic [2:0]  shamt2;
    logic [5:0]  constant2;

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0]  pc_exp;
    logic [3:0]  ex_op;
    logic [15:0] ex_rs, ex_rt;
    logic [5:0]  ex_const;
    logic [1:0]  wrap_exp [4];

    instr_fetch_decode #(.PC_WIDTH(8), .RESET_PC(8'd0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .op_code(op_code), .rs_val(rs_val), .rt_val(rt_val), .shamt(shamt), .constant(constant),
        .alu_rd(alu_rd), .alu_hi(alu_hi), .alu_lo(alu_lo),
        .pc(pc), .busy(busy), .halted(halted), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // NOP stream with ack always high; the ALU outputs are irrelevant for NOPs
    instr_fetch_decode #(.PC_WIDTH(2), .RESET_PC(2'd0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(1'b1), .imem_data(16'hC000),
        .op_code(op_code2), .rs_val(rs_val2), .rt_val(rt_val2), .shamt(shamt2), .constant(constant2),
        .alu_rd(16'h0000), .alu_hi(16'h0000), .alu_lo(16'h0000),
        .pc(pc2), .busy(busy2), .halted(halted2), .dbg_addr(3'd0), .dbg_data(dbg_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        logic [31:0] prod;
        prod   = rs_val * rt_val;
        alu_hi = prod[31:16];
        alu_lo = prod[15:0];
        case (op_code)
            4'd0:    alu_rd = rs_val + rt_val;
            4'd1:    alu_rd = rs_val - rt_val;
            4'd2:    alu_rd = rs_val & rt_val;
            4'd3:    alu_rd = prod[15:0];
            4'd6:    alu_rd = rs_val << shamt;
            4'd7:    alu_rd = rs_val >> shamt;
            4'd8:    alu_rd = rs_val + {10'd0, constant};
            4'd9:    alu_rd = {10'd0, constant};
            4'd10:   alu_rd = rs_val | {10'd0, constant};
            default: alu_rd = 16'h0000;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic check_reg(input logic [2:0] idx, input logic [15:0] exp);
        dbg_addr = idx;
        #1;
        check($sformatf("reg_r%0d", idx), {16'd0, dbg_data}, {16'd0, exp});
    endtask

    // Entered at a negedge in FETCH; returns at the negedge of the next FETCH.
    task automatic run_instr(input logic [15:0] word, input int nwait);
        for (int i = 0; i < nwait; i++) begin
            check("stall_req", {31'd0, imem_req}, 32'd1);
            check("stall_addr", {24'd0, imem_addr}, {24'd0, pc_exp});
            check("stall_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        check("fetch_req", {31'd0, imem_req}, 32'd1);
        check("fetch_addr", {24'd0, imem_addr}, {24'd0, pc_exp});
        imem_ack  = 1'b1;
        imem_data = word;
        @(negedge clk);
        imem_ack  = 1'b0;
        imem_data = 16'h0000;
        check("decode_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        ex_op    = op_code;
        ex_rs    = rs_val;
        ex_rt    = rt_val;
        ex_const = constant;
        @(negedge clk);
        @(negedge clk);
        pc_exp = pc_exp + 8'd1;
        check("next_pc", {24'd0, pc}, {24'd0, pc_exp});
        check("next_req", {31'd0, imem_req}, 32'd1);
    endtask

    initial begin
        wrap_exp  = '{2'd1, 2'd2, 2'd3, 2'd0};
        rst_n     = 1'b0;
        start     = 1'b0;
        start2    = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 16'h0000;
        dbg_addr  = 3'd0;
        pc_exp    = 8'd0;

        @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_pc", {24'd0, pc}, 32'd0);
        check("rst_op", {28'd0, op_code}, 32'd0);
        check("rst_rs", {16'd0, rs_val}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_req", {31'd0, imem_req}, 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // li r1,5
        run_instr(16'h9205, 0);
        check("li_op", {28'd0, ex_op}, 32'd9);
        check("li_const", {26'd0, ex_const}, 32'd5);
        check_reg(3'd1, 16'd5);

        // add r2,r1,r1
        run_instr(16'h0448, 0);
        check("add_op", {28'd0, ex_op}, 32'd0);
        check("add_rs", {16'd0, ex_rs}, 32'd5);
        check("add_rt", {16'd0, ex_rt}, 32'd5);
        check_reg(3'd2, 16'd10);

        // mul r2,r2 -> hi=0 lo=100, no register write
        run_instr(16'h3090, 0);
        check("mul_op", {28'd0, ex_op}, 32'd3);
        check_reg(3'd2, 16'd10);
        check_reg(3'd0, 16'd0);
        run_instr(16'h4600, 0);
        check_reg(3'd3, 16'd100);
        run_instr(16'h5800, 0);
        check_reg(3'd4, 16'd0);
        check_reg(3'd3, 16'd100);

        // li r5,63 with 5 cycles of withheld ack
        run_instr(16'h9A3F, 5);
        check_reg(3'd5, 16'd63);

        // li r0,7 is discarded
        run_instr(16'h9007, 0);
        check_reg(3'd0, 16'd0);
        check_reg(3'd5, 16'd63);

        // asynchronous reset mid-FETCH, well before the next rising edge
        check("prereset_req", {31'd0, imem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req", {31'd0, imem_req}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_pc", {24'd0, pc}, 32'd0);
        check("arst_op", {28'd0, op_code}, 32'd0);
        check("arst_const", {26'd0, constant}, 32'd0);
        check_reg(3'd1, 16'd0);
        check_reg(3'd3, 16'd0);
        check_reg(3'd5, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        pc_exp = 8'd0;
        check("refetch_req", {31'd0, imem_req}, 32'd1);
        check("refetch_addr", {24'd0, imem_addr}, 32'd0);

        // halt
        imem_ack  = 1'b1;
        imem_data = 16'hF000;
        @(negedge clk);
        imem_ack  = 1'b0;
        imem_data = 16'h0000;
        check("halt_dec_busy", {31'd0, busy}, 32'd1);
        check("halt_dec_halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        check("halt_halted", {31'd0, halted}, 32'd1);
        check("halt_busy", {31'd0, busy}, 32'd0);
        check("halt_req", {31'd0, imem_req}, 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("halt_sticky", {31'd0, halted}, 32'd1);
        check("halt_sticky_busy", {31'd0, busy}, 32'd0);
        check("halt_pc", {24'd0, pc}, 32'd0);

        // PC wrap on the 2-bit instance
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check("wrap_start_pc", {30'd0, pc2}, 32'd0);
        check("wrap_start_req", {31'd0, imem_req2}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            repeat (4) @(negedge clk);
            check($sformatf("wrap_pc_%0d", k), {30'd0, pc2}, {30'd0, wrap_exp[k]});
        end
        check("wrap_addr", {30'd0, imem_addr2}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
Multi-cycle fetch/decode/writeback controller placed directly upstream of the 16-bit ALU.
- Fetches 16-bit instructions from instruction memory over a req/ack handshake.
- Decodes each instruction and drives the ALU operand/control inputs from an 8x16 register file.
- Captures the ALU result one cycle later and writes it back.
- Owns the architectural hi/lo registers, the PC and the run/halt state.

Parameters:
PC_WIDTH, 8, instruction address width; PC wraps modulo 2^PC_WIDTH
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins execution from IDLE
imem_req  out  1  instruction fetch request
imem_addr  out  PC_WIDTH  fetch address (= pc)
imem_ack  in  1  imem_data valid this cycle
imem_data  in  16  instruction word
op_code  out  4  to ALU
rs_val  out  16  to ALU rs
rt_val  out  16  to ALU rt
shamt  out  3  to ALU
constant  out  6  to ALU, raw 6-bit field
alu_rd  in  16  ALU result
alu_hi  in  16  ALU product high half
alu_lo  in  16  ALU product low half
pc  out  PC_WIDTH  current PC
busy  out  1  high in FETCH/DECODE/EXEC/WB
halted  out  1  high in HALT
dbg_addr  in  3  register-file debug read index
dbg_data  out  16  combinational read of reg[dbg_addr]

Behaviour:
Decode fields:
- op = ir[15:12], rd = ir[11:9], rs = ir[8:6]
- R-type: rt = ir[5:3], shamt = ir[2:0]
- I-type (op 8-11): constant = ir[5:0]

Reset (async, rst_n low):
- State goes to IDLE, pc = RESET_PC.
- ir, hi_reg, lo_reg, all registers, op_code, rs_val, rt_val, shamt, constant are all 0.
- imem_req, busy and halted are 0.
- Takes effect immediately, including mid-fetch; imem_req drops without waiting for a clock edge.

FSM states:
- IDLE: start=1 -> FETCH.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack, capture ir=imem_data -> DECODE. Without ack, stay with req and addr held stable, indefinitely.
- DECODE: register op_code, shamt, constant, rs_val=reg[rs], rt_val=reg[rt]. If op=15 -> HALT, else -> EXEC.
- EXEC: ALU inputs are stable. On the exiting edge, capture alu_rd, alu_hi, alu_lo into internal result registers -> WB.
- WB: write-back per the table below. pc <= pc+1, wrapping from 2^PC_WIDTH-1 to 0 -> FETCH.
- HALT: terminal until reset. start is ignored.

start asserted outside IDLE is ignored.

Latency:
- Instruction cost is 3 cycles + fetch cycles; FETCH lasts 1 cycle when ack is immediate.
- The next fetch request is issued the cycle after WB.

Write-back by op:
- 0,1,2,6,7,8,9,10: reg[rd] = captured alu_rd.
- 3: hi_reg = captured alu_hi, lo_reg = captured alu_lo. No register write.
- 4: reg[rd] = lo_reg. 5: reg[rd] = hi_reg. Both use the block's own registers, not the ALU outputs.
- 11 (store): no register write.
- 12-14: NOP, no write.

Register file rules:
- reg[0] always reads 0; writes to r0 are discarded.
- No hazards: a register read in DECODE always observes the preceding instruction's WB.

Output outside DECODE/EXEC: op_code, rs_val, rt_val, shamt and constant hold their last values.

Test Plan:
1. Reset, start; imem returns 0x9205 (li r1,5) with immediate ack; ALU model -> imem_addr=0 req'd; in EXEC op_code=9, constant=5; after WB dbg r1=5, pc=1; next FETCH 4 cycles after the first.
2. Next word 0x0448 (add r2,r1,r1) -> rs_val=5, rt_val=5, op_code=0; after WB r2=10.
3. mul r2,r2 (0x3090), then op4 rd=r3 (0x4600), then op5 rd=r4 (0x5800) -> hi_reg=0, lo_reg=100; r3=100, r4=0; no register written by the mul.
4. Hold imem_ack low 5 cycles in FETCH -> imem_req stays 1, imem_addr constant, pc unchanged, no state advance; ack on cycle 6 proceeds normally.
5. Word 0x9007 (li r0,7) -> dbg r0 reads 0. Word 0xF000 -> halted=1 and busy=0 the cycle after DECODE; a later start pulse leaves state in HALT. With PC_WIDTH=2 and 4 NOPs, pc wraps 3 -> 0.
6. Assert rst_n low mid-FETCH (req=1) -> imem_req=0, busy=0 and all registers 0 before the next clk edge; after release, start refetches from RESET_PC.
